// File: rtl/interval_meter_pkg.sv
// Shared definitions for interval_meter: FSM state encoding and default width.
package interval_meter_pkg;

  // Default counter/result width, shared with the tick generator delay width.
  localparam int unsigned DEFAULT_WIDTH = 26;

  // FSM state encoding, kept as plain constants for legacy tool compatibility.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'b00;
  localparam state_t S_RUN  = 2'b01;
  localparam state_t S_DONE = 2'b10;

endpackage

// File: rtl/interval_meter_sat_up_counter.sv
// Saturating up-counter: clears to zero, adds inc each edge, never passes limit.
module sat_up_counter
  import interval_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_c_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Candidate next value and whether it lands exactly on the limit.
  always_comb begin
    count_d      = count_q + WIDTH'(inc_i);
    at_limit_c_o = (count_d == limit_i);
  end

  // Count register; holds once the limit is reached so it can never wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (count_q != limit_i) begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/interval_meter.sv
// Measures enabled cycles between start and stop, saturating at TIMEOUT,
// and hands the result over with a valid/ack handshake.
// Optional: define INTERVAL_METER_BEST_EN to track the minimum non-timeout result.
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int unsigned     WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(50_000_000)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  output logic [WIDTH-1:0] interval,
  output logic             valid,
  output logic             timeout,
  output logic             busy,
  output logic [WIDTH-1:0] best_interval
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] interval_q, interval_d;
  logic             timeout_q, timeout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             clear_c;
  logic             inc_c;
  logic [WIDTH-1:0] count_c;
  logic [WIDTH-1:0] sum_c;
  logic             at_limit_c;

  assign inc_c = enable && (state_q == S_RUN);
  assign sum_c = count_c + WIDTH'(inc_c);

  sat_up_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk          (clk),
    .resetn       (resetn),
    .clear_i      (clear_c),
    .inc_i        (inc_c),
    .limit_i      (TIMEOUT),
    .count_o      (count_c),
    .at_limit_c_o (at_limit_c)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic; stop wins over saturation on the same edge.
  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    timeout_d  = timeout_q;
    clear_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          clear_c = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d    = S_DONE;
          interval_d = sum_c;
          timeout_d  = 1'b0;
        end else if (at_limit_c) begin
          state_d    = S_DONE;
          interval_d = TIMEOUT;
          timeout_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (ack) begin
          if (start) begin
            state_d = S_RUN;
            clear_c = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    valid_d = (state_d == S_DONE);
    busy_d  = (state_d == S_RUN);
  end

  // Registered result and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      interval_q <= '0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      interval_q <= interval_d;
      timeout_q  <= timeout_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign interval = interval_q;
  assign timeout  = timeout_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

`ifdef INTERVAL_METER_BEST_EN
  logic [WIDTH-1:0] best_q, best_d;

  // Capture a new minimum when a stop-terminated measurement completes.
  always_comb begin
    best_d = best_q;
    if ((state_q == S_RUN) && (state_d == S_DONE) && !timeout_d && (interval_d < best_q)) begin
      best_d = interval_d;
    end
  end

  // Best-result register; only reset returns it to all ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      best_q <= '1;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_interval = best_q;
`else
  assign best_interval = '1;
`endif

endmodule

// File: tb/tb_interval_meter.sv
// Directed self-checking bench for interval_meter (TIMEOUT reduced to 100).
module tb_interval_meter;

  localparam int unsigned W = 26;
  localparam logic [W-1:0] ONES = '1;

  logic         clk;
  logic         resetn;
  logic         enable;
  logic         start;
  logic         stop;
  logic         ack;
  logic [W-1:0] interval;
  logic         valid;
  logic         timeout;
  logic         busy;
  logic [W-1:0] best_interval;

  int checks = 0;
  int errors = 0;

  interval_meter #(
    .WIDTH   (W),
    .TIMEOUT (26'd100)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .start         (start),
    .stop          (stop),
    .ack           (ack),
    .interval      (interval),
    .valid         (valid),
    .timeout       (timeout),
    .busy          (busy),
    .best_interval (best_interval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then stop on the k-th following edge (or none when use_stop=0).
  task automatic do_measure(input int k, input bit use_stop);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (k - 1) step();
    stop = use_stop;
    step();
    stop = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0d want 0", timeout); end
    checks++; if (interval !== '0) begin errors++; $display("FAIL reset_interval got %0d want 0", interval); end
    checks++; if (best_interval !== ONES) begin errors++; $display("FAIL reset_best got %0h want %0h", best_interval, ONES); end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    enable = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_run got %0d want 1", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_run got %0d want 0", valid); end
    repeat (6) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d want 1", valid); end
    checks++; if (interval !== 26'd7) begin errors++; $display("FAIL basic_interval got %0d want 7", interval); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %0d want 0", busy); end
    repeat (3) step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_hold_valid got %0d want 1", valid); end
    checks++; if (interval !== 26'd7) begin errors++; $display("FAIL basic_hold_interval got %0d want 7", interval); end
    do_ack();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_ack_valid got %0d want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_ack_busy got %0d want 0", busy); end
  endtask

  task automatic test_gated();
    enable = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      enable = ((i % 4) == 0);
      stop   = (i == 40);
      step();
    end
    stop   = 1'b0;
    enable = 1'b1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL gated_valid got %0d want 1", valid); end
    checks++; if (interval !== 26'd10) begin errors++; $display("FAIL gated_interval got %0d want 10", interval); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL gated_timeout got %0d want 0", timeout); end
    do_ack();
  endtask

  task automatic test_saturation();
    enable = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (99) step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sat_early_valid got %0d want 0", valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_early_busy got %0d want 1", busy); end
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %0d want 1", valid); end
    checks++; if (interval !== 26'd100) begin errors++; $display("FAIL sat_interval got %0d want 100", interval); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL sat_timeout got %0d want 1", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_busy got %0d want 0", busy); end
    do_ack();
    do_measure(100, 1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL prio_valid got %0d want 1", valid); end
    checks++; if (interval !== 26'd100) begin errors++; $display("FAIL prio_interval got %0d want 100", interval); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL prio_timeout got %0d want 0", timeout); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    do_measure(3, 1'b1);
    checks++; if (interval !== 26'd3) begin errors++; $display("FAIL b2b_first got %0d want 3", interval); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_noack_valid got %0d want 1", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_noack_busy got %0d want 0", busy); end
    checks++; if (interval !== 26'd3) begin errors++; $display("FAIL b2b_noack_interval got %0d want 3", interval); end
    ack   = 1'b1;
    start = 1'b1;
    step();
    ack   = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0d want 1", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %0d want 0", valid); end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %0d want 1", valid); end
    checks++; if (interval !== 26'd5) begin errors++; $display("FAIL b2b_second_interval got %0d want 5", interval); end
    do_ack();
    stop = 1'b1;
    ack  = 1'b1;
    step();
    stop = 1'b0;
    ack  = 1'b0;
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_stop_valid got %0d want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_stop_busy got %0d want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    enable = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (37) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %0d want 1", busy); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0d want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d want 0", valid); end
    checks++; if (interval !== '0) begin errors++; $display("FAIL rst_interval got %0d want 0", interval); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0d want 0", timeout); end
    checks++; if (best_interval !== ONES) begin errors++; $display("FAIL rst_best got %0h want %0h", best_interval, ONES); end
    @(negedge clk);
    resetn = 1'b1;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_stop_valid got %0d want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_stop_busy got %0d want 0", busy); end
  endtask

  task automatic test_best();
    logic [W-1:0] exp_a, exp_b;
`ifdef INTERVAL_METER_BEST_EN
    exp_a = 26'd12;
    exp_b = 26'd8;
`else
    exp_a = ONES;
    exp_b = ONES;
`endif
    enable = 1'b1;
    do_measure(12, 1'b1);
    checks++; if (best_interval !== exp_a) begin errors++; $display("FAIL best_12 got %0h want %0h", best_interval, exp_a); end
    do_ack();
    do_measure(8, 1'b1);
    checks++; if (best_interval !== exp_b) begin errors++; $display("FAIL best_8 got %0h want %0h", best_interval, exp_b); end
    do_ack();
    do_measure(100, 1'b0);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL best_to_flag got %0d want 1", timeout); end
    checks++; if (best_interval !== exp_b) begin errors++; $display("FAIL best_timeout got %0h want %0h", best_interval, exp_b); end
    do_ack();
    do_measure(9, 1'b1);
    checks++; if (interval !== 26'd9) begin errors++; $display("FAIL best_9_interval got %0d want 9", interval); end
    checks++; if (best_interval !== exp_b) begin errors++; $display("FAIL best_9 got %0h want %0h", best_interval, exp_b); end
    do_ack();
  endtask

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    ack    = 1'b0;
    test_reset();
    test_basic();
    test_gated();
    test_saturation();
    test_back_to_back();
    test_reset_mid_run();
    test_best();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
